id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Applies the forwarding unit's operand-select codes to ID-stage register-file data and latches the resolved operands and control into the EX stage.
- Detects load-use hazards and raises LoadUse so the PC and IF/ID registers hold. On that cycle it inserts a bubble into EX.
- Handles branch/jump flush and global pipeline stall; keeps a saturating bubble counter for performance reporting.

Parameters:
- DATA_W, 32, datapath width
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Stall  in  1  global pipeline hold (e.g. memory busy)
- Flush  in  1  branch/jump taken; kill instruction entering EX
- Rs_ID, Rt_ID, WrAddr_ID  in  5 each  ID register indices and destination
- UsesRs_ID, UsesRt_ID  in  1 each  ID instruction reads Rs / Rt
- RegWr_ID, MemRd_ID, MemWr_ID, ALUSrc1_ID, ALUSrc2_ID  in  1 each  ID control
- ALUCtrl_ID  in  4  ALU operation
- RsData_ID, RtData_ID, Imm_ID  in  DATA_W each  register-file reads and extended immediate
- Rs_forward, Rt_forward, WrData_forward  in  2 each  forwarding selects (00 regfile, 01 MEM, 10 EX)
- ALUResult_EX  in  DATA_W  result of instruction currently in EX
- WrBackData_MEM  in  DATA_W  result of instruction currently in MEM
- Valid_EX  out  1  EX slot holds a real instruction
- RegWr_EX, MemRd_EX, MemWr_EX, ALUSrc1_EX, ALUSrc2_EX  out  1 each  latched control
- ALUCtrl_EX  out  4  latched ALU op
- WrAddr_EX, Rs_EX, Rt_EX  out  5 each  latched indices
- RsVal_EX, RtVal_EX, StoreData_EX, Imm_EX  out  DATA_W each  resolved operands
- LoadUse  out  1  combinational hazard flag to PC/IF-ID
- BubbleCnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (rst_n low, async):
  - All outputs and registers clear to 0, including Valid_EX=0 and BubbleCnt=0.
  - LoadUse evaluates to 0 because Valid_EX=0.
- Forward mux (combinational, pre-register):
  - Code 00 → ID data; 01 → WrBackData_MEM; 10 → ALUResult_EX; 11 → ID data (reserved).
  - RsVal uses Rs_forward on RsData_ID.
  - RtVal uses Rt_forward on RtData_ID.
  - StoreData uses WrData_forward on RtData_ID.
- LoadUse = Valid_EX & MemRd_EX & (WrAddr_EX!=0) & ((UsesRs_ID & Rs_ID==WrAddr_EX) | (UsesRt_ID & Rt_ID==WrAddr_EX)).
- Per-edge update priority, highest first:
  1. Flush: load bubble.
  2. Stall: hold all registers unchanged.
  3. LoadUse: load bubble; BubbleCnt+1.
  4. Otherwise: load ID fields and muxed operands; Valid_EX=1.
- Bubble contents:
  - Valid_EX=0, RegWr_EX=0, MemRd_EX=0, MemWr_EX=0, WrAddr_EX=0.
  - Data and other fields set to 0.
- Latency: one cycle, ID to EX.
- LoadUse stalls last exactly one cycle. After the bubble, MemRd_EX=0, so LoadUse drops and the dependent instruction reads from MEM via forward code 01.
- Flush with LoadUse in the same cycle: bubble is inserted, BubbleCnt unchanged.
- Stall with LoadUse: hold, BubbleCnt unchanged, LoadUse still driven.
- BubbleCnt saturates at all-ones and does not wrap.
- Reset asserted mid-operation clears state immediately, independent of clk.

Test Plan:
- Reset → EX outputs and counter zero: assert rst_n=0 mid-cycle with Valid_EX=1 → all outputs 0 before the next edge; release, then one normal ID instruction → Valid_EX=1 after 1 edge.
- EX forward: Rs_forward=10, ALUResult_EX=0x1234, RsData_ID=0xDEAD → RsVal_EX=0x1234 after edge. MEM forward: Rt_forward=01, WrBackData_MEM=0x55 → RtVal_EX=0x55. Split operand selects: WrData_forward=10 with Rt_forward=00 → StoreData_EX=ALUResult_EX, RtVal_EX=RtData_ID.
- Load-use: EX holds lw with WrAddr_EX=8; ID has Rs_ID=8, UsesRs_ID=1 → LoadUse=1. Next edge: Valid_EX=0, RegWr_EX=0, BubbleCnt=1. Following cycle: LoadUse=0.
- Load-use on $0: lw writing $0, ID reads $0 → LoadUse=0, no bubble, BubbleCnt unchanged.
- Flush priority: Flush=1 with Stall=1 and LoadUse=1 → bubble loaded, BubbleCnt unchanged. Stall alone → all EX outputs identical across 3 edges.
- Saturation: preload BubbleCnt via 2^CNT_W-1 load-use events (CNT_W=4 build) → BubbleCnt stays 15 on further events.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// It resolves the forwarded operands, detects load-use hazards and latches
// the ID instruction into the EX slot. A saturating counter records how
// many load-use bubbles have been inserted.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [4:0]        Rs_ID,
    input  logic [4:0]        Rt_ID,
    input  logic [4:0]        WrAddr_ID,
    input  logic              UsesRs_ID,
    input  logic              UsesRt_ID,
    input  logic              RegWr_ID,
    input  logic              MemRd_ID,
    input  logic              MemWr_ID,
    input  logic              ALUSrc1_ID,
    input  logic              ALUSrc2_ID,
    input  logic [3:0]        ALUCtrl_ID,
    input  logic [DATA_W-1:0] RsData_ID,
    input  logic [DATA_W-1:0] RtData_ID,
    input  logic [DATA_W-1:0] Imm_ID,
    input  logic [1:0]        Rs_forward,
    input  logic [1:0]        Rt_forward,
    input  logic [1:0]        WrData_forward,
    input  logic [DATA_W-1:0] ALUResult_EX,
    input  logic [DATA_W-1:0] WrBackData_MEM,
    output logic              Valid_EX,
    output logic              RegWr_EX,
    output logic              MemRd_EX,
    output logic              MemWr_EX,
    output logic              ALUSrc1_EX,
    output logic              ALUSrc2_EX,
    output logic [3:0]        ALUCtrl_EX,
    output logic [4:0]        WrAddr_EX,
    output logic [4:0]        Rs_EX,
    output logic [4:0]        Rt_EX,
    output logic [DATA_W-1:0] RsVal_EX,
    output logic [DATA_W-1:0] RtVal_EX,
    output logic [DATA_W-1:0] StoreData_EX,
    output logic [DATA_W-1:0] Imm_EX,
    output logic              LoadUse,
    output logic [CNT_W-1:0]  BubbleCnt
);

    // Everything held in the EX slot; an all-zero value is a bubble.
    typedef struct packed {
        logic              valid;
        logic              regwr;
        logic              memrd;
        logic              memwr;
        logic              alusrc1;
        logic              alusrc2;
        logic [3:0]        aluctrl;
        logic [4:0]        wraddr;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [DATA_W-1:0] rsval;
        logic [DATA_W-1:0] rtval;
        logic [DATA_W-1:0] stdata;
        logic [DATA_W-1:0] imm;
    } ex_slot_t;

    ex_slot_t          r_ex;
    ex_slot_t          w_ex_next;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_load_use;

    // Code 11 is reserved and falls back to the register-file value.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] id_d,
        input logic [DATA_W-1:0] mem_d,
        input logic [DATA_W-1:0] ex_d
    );
        case (sel)
            2'b01:   return mem_d;
            2'b10:   return ex_d;
            default: return id_d;
        endcase
    endfunction

    // Load in EX whose destination is a live source of the ID instruction.
    // Writes to $0 never create a dependency.
    always_comb begin
        w_load_use = r_ex.valid && r_ex.memrd && (r_ex.wraddr != 5'd0) &&
                     ((UsesRs_ID && (Rs_ID == r_ex.wraddr)) ||
                      (UsesRt_ID && (Rt_ID == r_ex.wraddr)));
    end

    // Next EX contents when the ID instruction is allowed to advance.
    always_comb begin
        w_ex_next         = '0;
        w_ex_next.valid   = 1'b1;
        w_ex_next.regwr   = RegWr_ID;
        w_ex_next.memrd   = MemRd_ID;
        w_ex_next.memwr   = MemWr_ID;
        w_ex_next.alusrc1 = ALUSrc1_ID;
        w_ex_next.alusrc2 = ALUSrc2_ID;
        w_ex_next.aluctrl = ALUCtrl_ID;
        w_ex_next.wraddr  = WrAddr_ID;
        w_ex_next.rs      = Rs_ID;
        w_ex_next.rt      = Rt_ID;
        w_ex_next.rsval   = fwd_sel(Rs_forward, RsData_ID, WrBackData_MEM, ALUResult_EX);
        w_ex_next.rtval   = fwd_sel(Rt_forward, RtData_ID, WrBackData_MEM, ALUResult_EX);
        w_ex_next.stdata  = fwd_sel(WrData_forward, RtData_ID, WrBackData_MEM, ALUResult_EX);
        w_ex_next.imm     = Imm_ID;
    end

    // EX slot update: flush beats stall, stall beats the load-use bubble.
    // Only a bubble caused by load-use is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex         <= '0;
            r_bubble_cnt <= '0;
        end else if (Flush) begin
            r_ex <= '0;
        end else if (Stall) begin
            r_ex <= r_ex;
        end else if (w_load_use) begin
            r_ex <= '0;
            if (r_bubble_cnt != {CNT_W{1'b1}})
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end else begin
            r_ex <= w_ex_next;
        end
    end

    assign Valid_EX     = r_ex.valid;
    assign RegWr_EX     = r_ex.regwr;
    assign MemRd_EX     = r_ex.memrd;
    assign MemWr_EX     = r_ex.memwr;
    assign ALUSrc1_EX   = r_ex.alusrc1;
    assign ALUSrc2_EX   = r_ex.alusrc2;
    assign ALUCtrl_EX   = r_ex.aluctrl;
    assign WrAddr_EX    = r_ex.wraddr;
    assign Rs_EX        = r_ex.rs;
    assign Rt_EX        = r_ex.rt;
    assign RsVal_EX     = r_ex.rsval;
    assign RtVal_EX     = r_ex.rtval;
    assign StoreData_EX = r_ex.stdata;
    assign Imm_EX       = r_ex.imm;
    assign LoadUse      = w_load_use;
    assign BubbleCnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage (CNT_W=4 so saturation is reachable).
// The driver pushes the hand-computed EX state expected after each edge,
// plus the LoadUse level expected during that cycle; the monitor pops and
// compares.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Stall = 1'b0, Flush = 1'b0;
    logic [4:0] Rs_ID = '0, Rt_ID = '0, WrAddr_ID = '0;
    logic UsesRs_ID = 0, UsesRt_ID = 0, RegWr_ID = 0, MemRd_ID = 0, MemWr_ID = 0;
    logic ALUSrc1_ID = 0, ALUSrc2_ID = 0;
    logic [3:0] ALUCtrl_ID = '0;
    logic [DW-1:0] RsData_ID = '0, RtData_ID = '0, Imm_ID = '0;
    logic [1:0] Rs_forward = '0, Rt_forward = '0, WrData_forward = '0;
    logic [DW-1:0] ALUResult_EX = 32'h1234, WrBackData_MEM = 32'h55;
    logic Valid_EX, RegWr_EX, MemRd_EX, MemWr_EX, ALUSrc1_EX, ALUSrc2_EX, LoadUse;
    logic [3:0] ALUCtrl_EX;
    logic [4:0] WrAddr_EX, Rs_EX, Rt_EX;
    logic [DW-1:0] RsVal_EX, RtVal_EX, StoreData_EX, Imm_EX;
    logic [CW-1:0] BubbleCnt;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .WrAddr_ID(WrAddr_ID),
        .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
        .RegWr_ID(RegWr_ID), .MemRd_ID(MemRd_ID), .MemWr_ID(MemWr_ID),
        .ALUSrc1_ID(ALUSrc1_ID), .ALUSrc2_ID(ALUSrc2_ID), .ALUCtrl_ID(ALUCtrl_ID),
        .RsData_ID(RsData_ID), .RtData_ID(RtData_ID), .Imm_ID(Imm_ID),
        .Rs_forward(Rs_forward), .Rt_forward(Rt_forward), .WrData_forward(WrData_forward),
        .ALUResult_EX(ALUResult_EX), .WrBackData_MEM(WrBackData_MEM),
        .Valid_EX(Valid_EX), .RegWr_EX(RegWr_EX), .MemRd_EX(MemRd_EX), .MemWr_EX(MemWr_EX),
        .ALUSrc1_EX(ALUSrc1_EX), .ALUSrc2_EX(ALUSrc2_EX), .ALUCtrl_EX(ALUCtrl_EX),
        .WrAddr_EX(WrAddr_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
        .RsVal_EX(RsVal_EX), .RtVal_EX(RtVal_EX), .StoreData_EX(StoreData_EX), .Imm_EX(Imm_EX),
        .LoadUse(LoadUse), .BubbleCnt(BubbleCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs, rt, wa;
        logic urs, urt, regwr, memrd, memwr, as1, as2;
        logic [3:0] alu;
        logic [31:0] rsd, rtd, imm;
        logic [1:0] rsf, rtf, wdf;
    } in_t;

    typedef struct packed {
        logic [7:0] tag;
        logic lu, v, regwr, memrd, memwr;
        logic [3:0] alu;
        logic [4:0] wa, rs, rt;
        logic [31:0] rsval, rtval, sd, imm;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] tag = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [4:0] rs, rt, wa, input logic urs, urt, regwr, memrd, memwr,
                               input logic [3:0] alu, input logic [31:0] rsd, rtd, imm,
                               input logic [1:0] rsf, rtf, wdf);
        in_t d;
        d.rs = rs; d.rt = rt; d.wa = wa; d.urs = urs; d.urt = urt;
        d.regwr = regwr; d.memrd = memrd; d.memwr = memwr;
        d.as1 = 1'b0; d.as2 = memrd | memwr; d.alu = alu;
        d.rsd = rsd; d.rtd = rtd; d.imm = imm;
        d.rsf = rsf; d.rtf = rtf; d.wdf = wdf;
        return d;
    endfunction

    // Control fields pass straight through; operands are given by hand.
    function automatic exp_t exp_load(input in_t d, input logic [31:0] rsv, rtv, sdv,
                                      input logic [3:0] cnt, input logic lu);
        exp_t e = '0;
        e.lu = lu; e.v = 1'b1; e.regwr = d.regwr; e.memrd = d.memrd; e.memwr = d.memwr;
        e.alu = d.alu; e.wa = d.wa; e.rs = d.rs; e.rt = d.rt;
        e.rsval = rsv; e.rtval = rtv; e.sd = sdv; e.imm = d.imm; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t exp_bub(input logic [3:0] cnt, input logic lu);
        exp_t e = '0;
        e.lu = lu; e.cnt = cnt;
        return e;
    endfunction

    task automatic step(input logic st, input logic fl, input in_t d, input exp_t e);
        @(negedge clk);
        Stall = st; Flush = fl;
        Rs_ID = d.rs; Rt_ID = d.rt; WrAddr_ID = d.wa; UsesRs_ID = d.urs; UsesRt_ID = d.urt;
        RegWr_ID = d.regwr; MemRd_ID = d.memrd; MemWr_ID = d.memwr;
        ALUSrc1_ID = d.as1; ALUSrc2_ID = d.as2; ALUCtrl_ID = d.alu;
        RsData_ID = d.rsd; RtData_ID = d.rtd; Imm_ID = d.imm;
        Rs_forward = d.rsf; Rt_forward = d.rtf; WrData_forward = d.wdf;
        tag++;
        e.tag = tag;
        q.push_back(e);
        last = e;
    endtask

    // Monitor: LoadUse is sampled mid-cycle, EX state just after the edge.
    initial begin
        exp_t e;
        logic lu;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                lu = LoadUse;
                @(posedge clk);
                #1;
                e = q.pop_front();
                chk($sformatf("t%0d LoadUse", e.tag), 32'(lu), 32'(e.lu));
                chk($sformatf("t%0d Valid_EX", e.tag), 32'(Valid_EX), 32'(e.v));
                chk($sformatf("t%0d RegWr_EX", e.tag), 32'(RegWr_EX), 32'(e.regwr));
                chk($sformatf("t%0d MemRd_EX", e.tag), 32'(MemRd_EX), 32'(e.memrd));
                chk($sformatf("t%0d MemWr_EX", e.tag), 32'(MemWr_EX), 32'(e.memwr));
                chk($sformatf("t%0d ALUCtrl_EX", e.tag), 32'(ALUCtrl_EX), 32'(e.alu));
                chk($sformatf("t%0d WrAddr_EX", e.tag), 32'(WrAddr_EX), 32'(e.wa));
                chk($sformatf("t%0d Rs_EX", e.tag), 32'(Rs_EX), 32'(e.rs));
                chk($sformatf("t%0d Rt_EX", e.tag), 32'(Rt_EX), 32'(e.rt));
                chk($sformatf("t%0d RsVal_EX", e.tag), RsVal_EX, e.rsval);
                chk($sformatf("t%0d RtVal_EX", e.tag), RtVal_EX, e.rtval);
                chk($sformatf("t%0d StoreData_EX", e.tag), StoreData_EX, e.sd);
                chk($sformatf("t%0d Imm_EX", e.tag), Imm_EX, e.imm);
                chk($sformatf("t%0d BubbleCnt", e.tag), 32'(BubbleCnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_t a, lw8, lw0, dep, rd0;
        exp_t e;
        logic [3:0] cnt;

        a   = mk(5'd3, 5'd4, 5'd5, 1, 1, 1, 0, 0, 4'd2, 32'hDEAD, 32'hBEEF, 32'h10, 2'b00, 2'b00, 2'b00);
        lw8 = mk(5'd1, 5'd8, 5'd8, 1, 0, 1, 1, 0, 4'd0, 32'h100, 32'h0, 32'h4, 2'b00, 2'b00, 2'b00);
        lw0 = mk(5'd1, 5'd0, 5'd0, 1, 0, 1, 1, 0, 4'd0, 32'h100, 32'h0, 32'h4, 2'b00, 2'b00, 2'b00);
        dep = mk(5'd8, 5'd9, 5'd10, 1, 1, 1, 0, 0, 4'd2, 32'h11, 32'h22, 32'h0, 2'b00, 2'b00, 2'b00);
        rd0 = mk(5'd0, 5'd0, 5'd3, 1, 1, 1, 0, 0, 4'd2, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);

        // Power-on reset state.
        repeat (2) @(negedge clk);
        chk("reset Valid_EX", 32'(Valid_EX), 32'd0);
        chk("reset RsVal_EX", RsVal_EX, 32'd0);
        chk("reset BubbleCnt", 32'(BubbleCnt), 32'd0);
        chk("reset LoadUse", 32'(LoadUse), 32'd0);
        rst_n = 1'b1;

        // Plain instruction, all operands from the register file.
        step(0, 0, a, exp_load(a, 32'hDEAD, 32'hBEEF, 32'hBEEF, 4'd0, 0));

        // Asynchronous reset in mid-cycle with a valid instruction in EX.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst Valid_EX", 32'(Valid_EX), 32'd0);
        chk("async rst RegWr_EX", 32'(RegWr_EX), 32'd0);
        chk("async rst WrAddr_EX", 32'(WrAddr_EX), 32'd0);
        chk("async rst RsVal_EX", RsVal_EX, 32'd0);
        chk("async rst StoreData_EX", StoreData_EX, 32'd0);
        chk("async rst LoadUse", 32'(LoadUse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rs from EX, Rt from MEM, store data from regfile.
        a.rsf = 2'b10; a.rtf = 2'b01; a.wdf = 2'b00;
        step(0, 0, a, exp_load(a, 32'h1234, 32'h55, 32'hBEEF, 4'd0, 0));
        // Split selects: Rt from regfile while store data comes from EX.
        a.rsf = 2'b01; a.rtf = 2'b00; a.wdf = 2'b10;
        step(0, 0, a, exp_load(a, 32'h55, 32'hBEEF, 32'h1234, 4'd0, 0));
        // Reserved code 11 on Rs/Rt selects the regfile value.
        a.rsf = 2'b11; a.rtf = 2'b11; a.wdf = 2'b01;
        step(0, 0, a, exp_load(a, 32'hDEAD, 32'hBEEF, 32'h55, 4'd0, 0));

        // Load-use: lw $8 in EX, dependent reads $8 -> bubble, count 1.
        step(0, 0, lw8, exp_load(lw8, 32'h100, 32'h0, 32'h0, 4'd0, 0));
        step(0, 0, dep, exp_bub(4'd1, 1));
        // Dependent re-issued, now forwarded from MEM.
        dep.rsf = 2'b01;
        step(0, 0, dep, exp_load(dep, 32'h55, 32'h22, 32'h22, 4'd1, 0));
        dep.rsf = 2'b00;

        // lw to $0 followed by reads of $0: no hazard.
        step(0, 0, lw0, exp_load(lw0, 32'h100, 32'h0, 32'h0, 4'd1, 0));
        step(0, 0, rd0, exp_load(rd0, 32'h0, 32'h0, 32'h0, 4'd1, 0));

        // Flush with Stall and LoadUse together: bubble, count unchanged.
        step(0, 0, lw8, exp_load(lw8, 32'h100, 32'h0, 32'h0, 4'd1, 0));
        step(1, 1, dep, exp_bub(4'd1, 1));

        // Stall with LoadUse: EX held for three edges, LoadUse still high.
        step(0, 0, lw8, exp_load(lw8, 32'h100, 32'h0, 32'h0, 4'd1, 0));
        e = last; e.lu = 1'b1;
        step(1, 0, dep, e);
        step(1, 0, dep, e);
        step(1, 0, dep, e);
        step(0, 0, dep, exp_bub(4'd2, 1));

        // Drive the counter to 15 and beyond; it must stick at 15.
        cnt = 4'd2;
        for (int i = 0; i < 15; i++) begin
            step(0, 0, lw8, exp_load(lw8, 32'h100, 32'h0, 32'h0, cnt, 0));
            if (cnt != 4'd15) cnt = cnt + 4'd1;
            step(0, 0, dep, exp_bub(cnt, 1));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", q.size(), 32'd0);
        chk("final BubbleCnt", 32'(BubbleCnt), 32'd15);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
